// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use stalling, EX forwarding, branch flush and data-memory freeze.
// Optional performance counters are included when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
    parameter int REG_W       = 5,
    parameter int ZERO_REG    = 31,
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic             branch_taken,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             pc_en,
    output logic             id_bubble,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events,
    output logic [31:0]      wait_cycles,
`endif
    output logic             mem_err
);

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [REG_W-1:0]  ZERO     = REG_W'(ZERO_REG);
    localparam logic [3:0]        LAT_M1   = 4'(LOAD_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN,
        LOAD_STALL
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        bub_cnt, bub_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              freeze;
    logic              hazard;

    assign freeze = dm_req & ~dm_ready;
    assign hazard = ex_memread & (ex_rd != ZERO) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            bub_cnt  <= '0;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bub_cnt  <= bub_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (freeze && (wait_cnt_nxt == WAIT_MAX)) begin
                mem_err <= 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        bub_cnt_nxt = bub_cnt;
        if (freeze) begin
            state_nxt   = state;
            bub_cnt_nxt = bub_cnt;
        end else if (branch_taken) begin
            state_nxt   = RUN;
            bub_cnt_nxt = '0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state_nxt   = LOAD_STALL;
                        bub_cnt_nxt = LAT_M1;
                    end
                end
                LOAD_STALL: begin
                    if (bub_cnt == 4'd1) begin
                        state_nxt   = RUN;
                        bub_cnt_nxt = '0;
                    end else begin
                        bub_cnt_nxt = bub_cnt - 4'd1;
                    end
                end
                default: begin
                    state_nxt   = RUN;
                    bub_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Wait counter tracks consecutive frozen cycles and saturates so mem_err stays meaningful.
    always_comb begin
        wait_cnt_nxt = '0;
        if (freeze) begin
            wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        id_bubble    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (freeze) begin
            pc_en = 1'b0;
        end else if (branch_taken) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if ((state == LOAD_STALL) || hazard) begin
            pc_en     = 1'b0;
            id_bubble = 1'b1;
        end
    end

    // Forwarding is independent of stall/freeze; MEM result is newer than WB so it wins.
    always_comb begin
        forwardA = 2'b00;
        if (mem_regwrite && (mem_rd == ex_rs1) && (mem_rd != ZERO)) begin
            forwardA = 2'b10;
        end else if (wb_regwrite && (wb_rd == ex_rs1) && (wb_rd != ZERO)) begin
            forwardA = 2'b01;
        end
    end

    always_comb begin
        forwardB = 2'b00;
        if (mem_regwrite && (mem_rd == ex_rs2) && (mem_rd != ZERO)) begin
            forwardB = 2'b10;
        end else if (wb_regwrite && (wb_rd == ex_rs2) && (wb_rd != ZERO)) begin
            forwardB = 2'b01;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
            wait_cycles  <= '0;
        end else begin
            if (id_bubble) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (!freeze && branch_taken) begin
                flush_events <= flush_events + 32'd1;
            end
            if (freeze) begin
                wait_cycles <= wait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the single-cycle load-use hazard detector and forwarding unit of the 5-stage LEGv8 pipeline. Merges load-use stalling with a configurable bubble count, EX-stage forwarding, branch-taken flushing and a data-memory wait freeze into one control block. Sits beside the datapath and drives the PC/IF_ID enables, ID_EX bubble mux, pipeline-register flushes and the EX operand forwarding muxes.

Parameters:
REG_W, 5, register-address width
ZERO_REG, 31, register index never forwarded or hazard-checked (XZR)
LOAD_LAT, 1, bubbles inserted per load-use hazard (1..15)
MEM_TIMEOUT, 64, consecutive wait cycles before mem_err sets (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_rs1, id_rs2  in  REG_W each  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads that source
ex_rs1, ex_rs2  in  REG_W each  source registers of the instruction in EX
ex_rd  in  REG_W  destination in EX
ex_memread  in  1  EX instruction is a load
mem_rd  in  REG_W  destination in MEM
mem_regwrite  in  1  MEM instruction writes a register
wb_rd  in  REG_W  destination in WB
wb_regwrite  in  1  WB instruction writes a register
branch_taken  in  1  PCSrc resolved in MEM
dm_req  in  1  MEM instruction accesses data memory
dm_ready  in  1  data memory completes this cycle
pc_en  out  1  PC and IF_ID enable
id_bubble  out  1  force ID_EX control fields to 0
flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  clear register next edge
forwardA, forwardB  out  2 each  00 regfile, 10 from MEM, 01 from WB
mem_err  out  1  sticky memory-timeout flag

Behaviour:
- Only clock is clk; reset synchronous, active-high. All outputs are combinational from state and inputs except mem_err (registered).
- Reset: state RUN, bubble counter 0, wait counter 0, mem_err 0. With all inputs idle: pc_en=1, id_bubble=0, flushes 0, forwardA=forwardB=00.
- Forwarding (always active, even while frozen): forwardA=10 if mem_regwrite & mem_rd==ex_rs1 & mem_rd!=ZERO_REG; else 01 if wb_regwrite & wb_rd==ex_rs1 & wb_rd!=ZERO_REG; else 00. forwardB is the same using ex_rs2. MEM has priority over WB.
- Hazard condition: ex_memread & ex_rd!=ZERO_REG & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Freeze condition: dm_req & ~dm_ready.
- Output priority, highest first:
  - freeze: pc_en=0, id_bubble=0, no flushes. State and bubble counter hold. Wait counter increments.
  - branch_taken: all three flushes=1, pc_en=1, id_bubble=0. Next state is RUN and bubble counter clears, so any in-progress load stall is cancelled.
  - load stall: pc_en=0, id_bubble=1.
- FSM:
  - RUN: on hazard (no freeze or flush), stall this cycle. If LOAD_LAT>1, go to LOAD_STALL with counter=LOAD_LAT-1.
  - LOAD_STALL: pc_en=0, id_bubble=1, hazard not re-evaluated. Counter decrements each unfrozen cycle; return to RUN on the edge where the counter equals 1.
  - Total bubbles per hazard is exactly LOAD_LAT.
- Wait counter: clears on any non-freeze cycle and saturates at MEM_TIMEOUT. mem_err sets on the edge where the counter reaches MEM_TIMEOUT and clears only on reset.
- Reset asserted mid-stall or mid-freeze: the next cycle is the full reset state.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0], flush_events[31:0], wait_cycles[31:0]. They count cycles with id_bubble=1, cycles with branch_taken flushes, and freeze cycles, respectively. Counters wrap at 2^32 and clear on reset.
- Undefined: ports and logic are absent; remaining behaviour is identical.

Test Plan:
- LOAD_LAT=1: LDUR X2 in EX (ex_rd=2, ex_memread=1), ID id_rs1=2, id_use_rs1=1 -> one cycle pc_en=0, id_bubble=1, then pc_en=1.
- LOAD_LAT=3, same hazard -> exactly 3 consecutive cycles pc_en=0/id_bubble=1. With dm_req=1, dm_ready=0 for 2 cycles mid-stall -> stall stretched to 5 cycles; id_bubble=0 during the frozen cycles.
- mem_rd=wb_rd=5, both regwrite=1, ex_rs1=5 -> forwardA=10. Then mem_regwrite=0 -> 01. Then all rd=31 -> 00.
- LOAD_LAT=4 stall in progress, branch_taken=1 on the 2nd stall cycle -> all flushes=1 and pc_en=1 that cycle, RUN next cycle with no further bubbles.
- MEM_TIMEOUT=4, dm_req=1, dm_ready=0 held -> mem_err=1 after the 4th frozen edge. It stays 1 after dm_ready=1 and clears only on reset.
- HAZARD_PERF_CNT_EN defined: run the second scenario -> stall_cycles=3, wait_cycles=2, flush_events=0.
